key_filter_bank: RTL and testbench
==================================

# key_filter_bank

Multi-channel, parametrised successor to the single-bit key-to-LED flip-flop. Each channel synchronises a raw push-button input into `sys_clk`, filters contact bounce with a per-channel stability counter, and emits a one-cycle press flag. Each channel then drives its LED either as a registered follower of the filtered key or as a press-to-toggle latch. It sits between the board key pins and the LED pins, and other logic may consume the press flags.

## Interface
- `CH`, 4: number of independent key/LED channels (1..16).
- `CNT_MAX`, 999_999: stability count. 20 ms at 50 MHz. Counter width is `$clog2(CNT_MAX+1)`.
- `KEY_ACTIVE`, 1'b0: `key_in` level that means "pressed". Board keys are active-low.

- `sys_clk`, input, 1: 50 MHz system clock. This is the only clock.
- `sys_rst_n`, input, 1: reset, asynchronous and active-low.
- `key_in`, input, CH: raw, asynchronous key pins.
- `mode`, input, CH: per-channel mode. 0 = follow, 1 = toggle. Synchronous to `sys_clk` and quasi-static.
- `key_state`, output, CH: filtered key level. 1 = pressed.
- `key_flag`, output, CH: one-cycle pulse on each filtered press.
- `led_out`, output, CH: LED drive. 1 = LED on.

## Operation
- Synchroniser, per channel: two flops, `s1` then `s2`. Both reset to `~KEY_ACTIVE`. "Pressed" means `s2 == KEY_ACTIVE`.
- Per-channel FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter `cnt`:
  - IDLE:
    - pressed → PRESS_WAIT, `cnt <= 0`.
  - PRESS_WAIT:
    - released → IDLE, `cnt <= 0`.
    - else if `cnt == CNT_MAX` → PRESSED, with a `key_flag` pulse.
    - else `cnt <= cnt + 1`.
  - PRESSED:
    - released → RELEASE_WAIT, `cnt <= 0`.
  - RELEASE_WAIT:
    - pressed → PRESSED, `cnt <= 0`, no flag.
    - else if `cnt == CNT_MAX` → IDLE.
    - else increment `cnt`.
- `key_state` is 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT. It is registered.
- `key_flag` is registered and high for exactly one cycle, on the edge that enters PRESSED from PRESS_WAIT.
- `led_out` is registered and updates on the same edge as `key_state` and `key_flag`:
  - Follow mode: `led_out <= next key_state`.
  - Toggle mode: `led_out <= led_out ^ next key_flag`.
- Mode change:
  - Follow to toggle: `led_out` holds its value.
  - Toggle to follow: `led_out` takes `key_state` on the next edge.
  - A flag that coincides with the mode change is evaluated under the new mode.
- The counter saturates logically: it never wraps, because the state leaves the wait state at `CNT_MAX`.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous flags.

## Timing
- Reset (async assert, release sampled on `sys_clk`):
  - FSM is IDLE and `cnt` = 0.
  - Synchroniser flops = `~KEY_ACTIVE`.
  - `key_state` = 0, `key_flag` = 0, `led_out` = 0.
- Reset mid-debounce or mid-press abandons the operation. No flag is produced.
- Let `key_in` first be sampled pressed at edge k and held:
  - `s2` is pressed after edge k+1.
  - PRESS_WAIT is entered at edge k+2.
  - `key_state`, `key_flag` and `led_out` change at edge k+CNT_MAX+3.
- Release latency is symmetric: `key_state` clears at edge k'+CNT_MAX+3. No flag is produced on release.
- Bounce shorter than CNT_MAX+1 cycles of stable level produces no output change.

## Configuration
- Macro: `KEY_FILTER_EN`.
- Defined: the full debounce FSM described above, with `CNT_MAX` honoured.
- Undefined:
  - No counter and no wait states. IDLE ↔ PRESSED directly.
  - `key_state`, `key_flag` and `led_out` change at edge k+2.
  - `CNT_MAX` is ignored.
  - The synchroniser is retained.

## Test plan
The bench uses `CH`=4 and `CNT_MAX`=9, with `KEY_FILTER_EN` defined unless stated otherwise.
- **Reset:** Hold `sys_rst_n`=0 for 3 cycles with `key_in`=4'b0000. Required: all outputs are 0 throughout. After release, with keys still low (pressed), `key_flag[3:0]` pulses 4'b1111 exactly once, 12 cycles after the first sample edge.
- **Follow mode, clean press:** `mode`=0. Drive ch0 low for 30 cycles, then high. Required: `led_out[0]` rises at edge k+12 and falls 12 cycles after the release is sampled. `key_flag[0]` is high for exactly 1 cycle.
- **Bounce rejection:** Toggle ch1 every 5 cycles for 60 cycles. Required: `key_state[1]`, `key_flag[1]` and `led_out[1]` stay 0.
- **Toggle mode:** `mode[2]`=1. Give ch2 three clean presses, each 20 cycles long and separated by 20 cycles. Required: `led_out[2]` sequence is 1, 0, 1, and there are 3 flags.
- **Reset mid-debounce:** Press ch3 and assert reset at `cnt`=5. Required: no flag, and outputs are 0 throughout.
- **Filter compiled out:** Build with `KEY_FILTER_EN` undefined and repeat the follow-mode case. Required: `led_out[0]` rises at edge k+2. The 5-cycle bounce toggles `key_state[1]` each time.

Source files
------------

// File: rtl/key_filter_bank_if.sv
// Key/LED channel bundle between board pins and the filter bank.
// master: drives key_in/mode; slave: drives key_state/key_flag/led_out.
interface key_filter_bank_if #(
  parameter int CH = 4
);
  logic [CH-1:0] key_in;
  logic [CH-1:0] mode;
  logic [CH-1:0] key_state;
  logic [CH-1:0] key_flag;
  logic [CH-1:0] led_out;

  modport master (
    output key_in,
    output mode,
    input  key_state,
    input  key_flag,
    input  led_out
  );

  modport slave (
    input  key_in,
    input  mode,
    output key_state,
    output key_flag,
    output led_out
  );
endinterface

// File: rtl/key_filter_bank.sv
// Per-channel key synchroniser, debounce FSM, press flag and LED driver.
// Ports: sys_clk, sys_rst_n (async low), bus (slave: key_in, mode ->
// key_state, key_flag, led_out). Macro KEY_FILTER_EN enables debounce.
module key_filter_bank #(
  parameter int   CH         = 4,
  parameter int   CNT_MAX    = 999_999,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  key_filter_bank_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [CH-1:0] r_s1;
  logic [CH-1:0] r_s2;
  logic [CH-1:0] w_key_state;
  logic [CH-1:0] w_key_flag;
  logic [CH-1:0] w_led_out;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1 <= {CH{~KEY_ACTIVE}};
      r_s2 <= {CH{~KEY_ACTIVE}};
    end else begin
      r_s1 <= bus.key_in;
      r_s2 <= r_s1;
    end
  end

`ifdef KEY_FILTER_EN
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = |CNT_MAX;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t r_state;
    state_t w_nstate;
    logic   w_pressed;
    logic   w_nflag;
    logic   w_nks;
    logic   w_nled;
    logic   r_ks;
    logic   r_flag;
    logic   r_led;

    assign w_pressed = (r_s2[i] == KEY_ACTIVE);

`ifdef KEY_FILTER_EN
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_ncnt;
    logic          w_done;

    assign w_done = (r_cnt == CW'(CNT_MAX));

    always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_nflag  = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pressed) begin
            w_nstate = PRESS_WAIT;
            w_ncnt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_pressed) begin
            w_nstate = IDLE;
            w_ncnt   = '0;
          end else if (w_done) begin
            w_nstate = PRESSED;
            w_nflag  = 1'b1;
          end else begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_pressed) begin
            w_nstate = RELEASE_WAIT;
            w_ncnt   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_pressed) begin
            w_nstate = PRESSED;
            w_ncnt   = '0;
          end else if (w_done) begin
            w_nstate = IDLE;
          end else begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
        default: w_nstate = IDLE;
      endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_cnt <= '0;
      else            r_cnt <= w_ncnt;
    end
`else
    always_comb begin
      w_nstate = r_state;
      w_nflag  = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pressed) begin
            w_nstate = PRESSED;
            w_nflag  = 1'b1;
          end
        end
        PRESSED: begin
          if (!w_pressed) w_nstate = IDLE;
        end
        default: w_nstate = IDLE;
      endcase
    end
`endif

    assign w_nks = (w_nstate == PRESSED) ||
                   (w_nstate == RELEASE_WAIT);
    // Mode is sampled on the same edge, so a coincident flag
    // is judged under the new mode.
    assign w_nled = bus.mode[i] ? (r_led ^ w_nflag) : w_nks;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_state <= IDLE;
        r_ks    <= 1'b0;
        r_flag  <= 1'b0;
        r_led   <= 1'b0;
      end else begin
        r_state <= w_nstate;
        r_ks    <= w_nks;
        r_flag  <= w_nflag;
        r_led   <= w_nled;
      end
    end

    assign w_key_state[i] = r_ks;
    assign w_key_flag[i]  = r_flag;
    assign w_led_out[i]   = r_led;
  end

  assign bus.key_state = w_key_state;
  assign bus.key_flag  = w_key_flag;
  assign bus.led_out   = w_led_out;
endmodule

// File: tb/tb_key_filter_bank.sv
// Self-checking bench for key_filter_bank (CH=4, CNT_MAX=9).
// Works with and without KEY_FILTER_EN defined.
module tb_key_filter_bank;
  localparam int CH      = 4;
  localparam int CNT_MAX = 9;
`ifdef KEY_FILTER_EN
  localparam int T = CNT_MAX + 2;
`else
  localparam int T = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  key_filter_bank_if #(.CH(CH)) bus ();

  key_filter_bank #(
    .CH(CH),
    .CNT_MAX(CNT_MAX),
    .KEY_ACTIVE(1'b0)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: a key level must disagree with the filtered level
  // for T consecutive synchronised samples before it is accepted.
  logic [3:0] m_s1, m_s2, m_ks, m_fl, m_led;
  int         m_run [4];

  function automatic void model_reset();
    m_s1 = '1;
    m_s2 = '1;
    m_ks = '0;
    m_fl = '0;
    m_led = '0;
    for (int c = 0; c < 4; c++) m_run[c] = 0;
  endfunction

  function automatic void model_step(input logic [3:0] key,
                                     input logic [3:0] mode);
    for (int c = 0; c < 4; c++) begin
      logic obs;
      obs = !m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = key[c];
      m_fl[c] = 1'b0;
      if (obs != m_ks[c]) begin
        m_run[c]++;
        if (m_run[c] == T) begin
          m_ks[c] = obs;
          m_fl[c] = obs;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_led[c] = mode[c] ? (m_led[c] ^ m_fl[c]) : m_ks[c];
    end
  endfunction

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic cmp_all();
    chk("key_state", bus.key_state, m_ks);
    chk("key_flag", bus.key_flag, m_fl);
    chk("led_out", bus.led_out, m_led);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(bus.key_in, bus.mode);
    #1;
    cmp_all();
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] mode;
    logic [3:0] ks;
    logic [3:0] fl;
    logic [3:0] led;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, first, pulses, rise, fall, fl0, chg, fl1, fl2, lchg, bad;
    int plen, hold[4];
    logic pv, pl;

    tbl[0] = '{1'b0, 4'b1111, 4'b0000, 4'b0, 4'b0, 4'b0};
    tbl[1] = '{1'b0, 4'b0101, 4'b1111, 4'b0, 4'b0, 4'b0};
    tbl[2] = '{1'b0, 4'b1010, 4'b0011, 4'b0, 4'b0, 4'b0};
    tbl[3] = '{1'b0, 4'b0000, 4'b0000, 4'b0, 4'b0, 4'b0};
    tbl[4] = '{1'b0, 4'b0000, 4'b0000, 4'b0, 4'b0, 4'b0};
    tbl[5] = '{1'b0, 4'b0000, 4'b0000, 4'b0, 4'b0, 4'b0};

    model_reset();
    bus.key_in = 4'b1111;
    bus.mode   = 4'b0000;
    #2;

    // Reset: table of held-reset vectors, outputs all zero.
    for (int i = 0; i < 6; i++) begin
      rst_n      = tbl[i].rst_n;
      bus.key_in = tbl[i].key;
      bus.mode   = tbl[i].mode;
      tick();
      chk("tbl_ks", bus.key_state, tbl[i].ks);
      chk("tbl_fl", bus.key_flag, tbl[i].fl);
      chk("tbl_led", bus.led_out, tbl[i].led);
    end

    // Release with all keys held pressed.
    rst_n = 1'b1;
    first = -1;
    pulses = 0;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (bus.key_flag == 4'b1111) begin
        if (first < 0) first = n;
        pulses++;
      end
    end
    chk_int("rst_flag_edge", first, T + 2);
    chk_int("rst_flag_pulses", pulses, 1);
    bus.key_in = 4'b1111;
    for (int i = 0; i < 20; i++) tick();

    // Follow mode, clean press on ch0.
    rise = -1;
    fall = -1;
    fl0 = 0;
    pl = bus.led_out[0];
    for (n = 1; n <= 60; n++) begin
      bus.key_in = (n <= 30) ? 4'b1110 : 4'b1111;
      tick();
      if (bus.led_out[0] && !pl && rise < 0) rise = n;
      if (!bus.led_out[0] && pl && fall < 0) fall = n;
      if (bus.key_flag[0]) fl0++;
      pl = bus.led_out[0];
    end
    chk_int("follow_rise", rise, T + 2);
    chk_int("follow_fall", fall, 30 + T + 2);
    chk_int("follow_flags", fl0, 1);

    // Bounce on ch1, 5-cycle half period.
    chg = 0;
    fl1 = 0;
    pv = bus.key_state[1];
    for (n = 0; n < 80; n++) begin
      bus.key_in = 4'b1111;
      if (n < 60 && ((n / 5) % 2 == 0)) bus.key_in[1] = 1'b0;
      tick();
      if (bus.key_state[1] != pv) chg++;
      if (bus.key_flag[1]) fl1++;
      pv = bus.key_state[1];
    end
    chk_int("bounce_changes", chg, (T == 1) ? 12 : 0);
    chk_int("bounce_flags", fl1, (T == 1) ? 6 : 0);

    // Toggle mode on ch2: three clean presses.
    bus.mode = 4'b0100;
    fl2 = 0;
    lchg = 0;
    pl = bus.led_out[2];
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 40; j++) begin
        bus.key_in = (j < 20) ? 4'b1011 : 4'b1111;
        tick();
        if (bus.key_flag[2]) fl2++;
        if (bus.led_out[2] != pl) lchg++;
        pl = bus.led_out[2];
      end
    end
    chk_int("toggle_flags", fl2, 3);
    chk_int("toggle_led_changes", lchg, 3);
    chk_int("toggle_led_final", int'(bus.led_out[2]), 1);
    bus.mode = 4'b0000;
    for (int i = 0; i < 5; i++) tick();

    // Reset in the middle of a ch3 debounce.
    bad = 0;
    plen = (T == 1) ? 2 : 8;
    bus.key_in = 4'b0111;
    for (int i = 0; i < plen; i++) begin
      tick();
      if (bus.key_flag[3] || bus.key_state[3] || bus.led_out[3]) bad++;
    end
    rst_n = 1'b0;
    bus.key_in = 4'b1111;
    model_reset();
    #1;
    cmp_all();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.key_flag[3] || bus.key_state[3] || bus.led_out[3]) bad++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.key_flag[3] || bus.key_state[3] || bus.led_out[3]) bad++;
    end
    chk_int("midreset_quiet", bad, 0);

    // Randomised run against the reference model.
    for (int c = 0; c < 4; c++) hold[c] = $urandom_range(1, 25);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          bus.key_in[c] = ~bus.key_in[c];
          hold[c] = $urandom_range(1, 25);
        end
      end
      if ($urandom_range(0, 59) == 0) bus.mode = 4'($urandom);
      if (rst_n && $urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_all();
      end else if (!rst_n) begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
